// File: rtl/ripple_carry_counter_pkg.sv
// Shared definitions for the ripple-carry counter slice.
// Default width and the count vector type used by users of the counter.
package ripple_carry_counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage

// File: rtl/ripple_carry_counter_t_ff.sv
// Toggle flip-flop with synchronous active-high clear.
// One counter stage; toggles on a rising edge when t is high.
module t_ff
    import ripple_carry_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (reset) begin
            q_d = 1'b0;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/ripple_carry_counter.sv
// Free-running up-counter built from a chain of toggle flip-flops.
// Every stage shares clk; only the toggle enables ripple combinationally.
module ripple_carry_counter
    import ripple_carry_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             reset
);

    // t_en[i] is high when all bits below i are set
    logic [WIDTH-1:0] t_en;

    assign t_en[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i > 0) begin : g_carry
            assign t_en[i] = t_en[i-1] & q[i-1];
        end

        t_ff u_t_ff (
            .clk  (clk),
            .reset(reset),
            .t    (t_en[i]),
            .q    (q[i])
        );
    end

endmodule

// File: tb/tb_ripple_carry_counter.sv
// Directed bench for ripple_carry_counter at WIDTH=4 and WIDTH=2.
// Expected counts come from a reference model through a scoreboard queue.
module tb_ripple_carry_counter;
    import ripple_carry_counter_pkg::*;

    typedef struct {
        string tag;
        int    e4;
        int    e2;
    } exp_t;

    logic       clk;
    logic       reset;
    count_t     q4;
    logic [1:0] q2;

    exp_t sb_q[$];
    int   model4;
    int   model2;
    int   checks;
    int   errors;

    ripple_carry_counter #(.WIDTH(4)) dut4 (
        .q    (q4),
        .clk  (clk),
        .reset(reset)
    );

    ripple_carry_counter #(.WIDTH(2)) dut2 (
        .q    (q2),
        .clk  (clk),
        .reset(reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input string tag);
        exp_t e;
        exp_t got;
        reset = r;
        model4 = r ? 0 : (model4 + 1) % 16;
        model2 = r ? 0 : (model2 + 1) % 4;
        e.tag = tag;
        e.e4  = model4;
        e.e2  = model2;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        assert (q4 === 4'(got.e4))
        else begin
            errors++;
            $error("FAIL %s w4: q=%0d expected %0d", got.tag, q4, got.e4);
        end
        checks++;
        assert (q2 === 2'(got.e2))
        else begin
            errors++;
            $error("FAIL %s w2: q=%0d expected %0d", got.tag, q2, got.e2);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model4 = 0;
        model2 = 0;
        reset  = 1'b1;

        step(1'b1, "pwr_rst0");
        step(1'b1, "pwr_rst1");

        for (int i = 0; i < 10; i++) step(1'b0, "count");

        step(1'b1, "wrap_rst");
        for (int i = 0; i < 17; i++) step(1'b0, "wrap");

        step(1'b1, "mid_rst0");
        for (int i = 0; i < 7; i++) step(1'b0, "mid_cnt");
        step(1'b1, "mid_rst");
        step(1'b0, "mid_resume");
        step(1'b0, "mid_resume2");

        step(1'b1, "term_rst0");
        for (int i = 0; i < 15; i++) step(1'b0, "term_cnt");
        step(1'b1, "term_rst");
        step(1'b1, "term_hold");
        step(1'b0, "term_resume");

        checks++;
        assert (sb_q.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain: left=%0d expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
